// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types, constants and helpers for the PS/2 device emulator.
//   ps2_dev_state_t : FSM state encoding of the frame serialiser
//   PS2_FRAME_BITS  : bits per PS/2 frame (start, 8 data, parity, stop)
//   PS2_STOP_IDX    : bit index of the stop bit within a frame
//   ps2_parity()    : odd parity over a data byte, optionally inverted
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BIT_HI,
    ST_BIT_LO,
    ST_GAP,
    ST_INHIBIT
  } ps2_dev_state_t;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_STOP_IDX   = 10;

  // Odd parity bit for a byte; err = 1 deliberately corrupts it.
  function automatic logic ps2_parity(input logic [7:0] data, input logic err);
    return (~^data) ^ err;
  endfunction

endpackage

// File: rtl/ps2_device_emulator_if.sv
// ps2_device_emulator_if: byte-queue write handshake of the PS/2 emulator.
//   tx_data  : scan-code byte to queue
//   tx_err   : send this byte with inverted parity
//   tx_valid : write request
//   tx_ready : queue has room (a write completes when valid && ready)
// master = producer of bytes, slave = the emulator.
interface ps2_device_emulator_if;
  logic [7:0] tx_data;
  logic       tx_err;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_err,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_err,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo: small synchronous FIFO of {err, data} entries.
//   clk, reset : clock, asynchronous active-high reset (empties the queue)
//   push, din  : write request and entry (ignored while full)
//   pop        : read request (ignored while empty)
//   full/empty : occupancy flags
//   dout       : head entry, valid whenever !empty (show-ahead read so the
//                consumer can latch it in the same cycle it pops)
module ps2_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [8:0] din,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [8:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ps2_byte_fifo: DEPTH must be a power of two >= 2");
  end

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_reg];

  // Storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ps2_device_emulator.sv
// ps2_device_emulator: PS/2 keyboard emulator. Queued scan-code bytes are
// serialised as 11-bit frames (start 0, data LSB first, odd parity, stop 1)
// on registered ps2_clk/ps2_data lines.
//   clk, reset    : system clock, asynchronous active-high reset
//   tx            : byte queue write port (slave side of the handshake)
//   host_inhibit  : host holds the clock low; aborts frames before the stop
//                   bit (retransmitted later) and stalls IDLE/GAP
//   ps2_clk/data  : PS/2 lines, idle high
//   busy          : frame activity in progress or bytes pending
//   frame_done    : one-cycle pulse in the last cycle of every stop bit
//   abort_count   : saturating count of aborted frames
module ps2_device_emulator
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int PS2_HZ     = 12_500,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 4 * (CLK_HZ / (2 * PS2_HZ))
) (
  input  logic                        clk,
  input  logic                        reset,
  ps2_device_emulator_if.slave        tx,
  input  logic                        host_inhibit,
  output logic                        ps2_clk,
  output logic                        ps2_data,
  output logic                        busy,
  output logic                        frame_done,
  output logic [7:0]                  abort_count
);

  localparam int HALF    = CLK_HZ / (2 * PS2_HZ);
  localparam int CNT_MAX = (HALF > GAP_CYCLES) ? HALF : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  if (HALF < 2) begin : g_bad_half
    $error("ps2_device_emulator: CLK_HZ/(2*PS2_HZ) must be at least 2");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("ps2_device_emulator: GAP_CYCLES must be at least 1");
  end

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic [8:0] fifo_dout;

  ps2_dev_state_t                  state_reg;
  logic [CNT_W-1:0]                cnt_reg;
  logic [3:0]                      idx_reg;
  logic [PS2_FRAME_BITS-1:0]       frame_reg;
  logic                            retry_reg;
  logic                            ps2_clk_reg;
  logic                            ps2_data_reg;
  logic                            frame_done_reg;
  logic [7:0]                      abort_count_reg;
  logic                            last_half;
  logic                            at_stop;

  assign tx.tx_ready = !fifo_full;
  // A pending retransmission re-uses frame_reg and must not consume a byte.
  assign fifo_pop    = (state_reg == ST_LOAD) && !retry_reg;

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx.tx_valid && !fifo_full),
    .din   ({tx.tx_err, tx.tx_data}),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  assign last_half = (cnt_reg == CNT_W'(HALF - 1));
  assign at_stop   = (idx_reg == 4'(PS2_STOP_IDX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      idx_reg         <= '0;
      frame_reg       <= '1;
      retry_reg       <= 1'b0;
      ps2_clk_reg     <= 1'b1;
      ps2_data_reg    <= 1'b1;
      frame_done_reg  <= 1'b0;
      abort_count_reg <= '0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (!host_inhibit && (retry_reg || !fifo_empty)) begin
            state_reg <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (!retry_reg) begin
            frame_reg <= {1'b1, ps2_parity(fifo_dout[7:0], fifo_dout[8]),
                          fifo_dout[7:0], 1'b0};
          end
          retry_reg    <= 1'b0;
          idx_reg      <= '0;
          cnt_reg      <= '0;
          ps2_clk_reg  <= 1'b1;
          ps2_data_reg <= 1'b0;  // start bit
          state_reg    <= ST_BIT_HI;
        end

        ST_BIT_HI, ST_BIT_LO: begin
          if (host_inhibit && !at_stop) begin
            // Back off: release both lines and replay the whole frame later.
            state_reg    <= ST_INHIBIT;
            ps2_clk_reg  <= 1'b1;
            ps2_data_reg <= 1'b1;
            retry_reg    <= 1'b1;
            cnt_reg      <= '0;
            if (abort_count_reg != 8'hFF) begin
              abort_count_reg <= abort_count_reg + 8'd1;
            end
          end else if (state_reg == ST_BIT_HI) begin
            if (last_half) begin
              cnt_reg     <= '0;
              ps2_clk_reg <= 1'b0;
              state_reg   <= ST_BIT_LO;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end else begin
            // Registered pulse: set one cycle early so it lands in the
            // final low-phase cycle of the stop bit.
            if (at_stop && (cnt_reg == CNT_W'(HALF - 2))) begin
              frame_done_reg <= 1'b1;
            end
            if (last_half) begin
              cnt_reg     <= '0;
              ps2_clk_reg <= 1'b1;
              if (at_stop) begin
                ps2_data_reg <= 1'b1;
                state_reg    <= ST_GAP;
              end else begin
                // Data only moves together with the rising clock edge.
                idx_reg      <= idx_reg + 4'd1;
                ps2_data_reg <= frame_reg[idx_reg + 4'd1];
                state_reg    <= ST_BIT_HI;
              end
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end

        ST_GAP: begin
          ps2_clk_reg  <= 1'b1;
          ps2_data_reg <= 1'b1;
          if (!host_inhibit) begin
            if (cnt_reg == CNT_W'(GAP_CYCLES - 1)) begin
              cnt_reg   <= '0;
              state_reg <= ST_IDLE;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end

        ST_INHIBIT: begin
          ps2_clk_reg  <= 1'b1;
          ps2_data_reg <= 1'b1;
          if (!host_inhibit) begin
            cnt_reg   <= '0;
            state_reg <= ST_GAP;
          end
        end

        default: begin
          state_reg    <= ST_IDLE;
          ps2_clk_reg  <= 1'b1;
          ps2_data_reg <= 1'b1;
        end
      endcase
    end
  end

  assign ps2_clk     = ps2_clk_reg;
  assign ps2_data    = ps2_data_reg;
  assign frame_done  = frame_done_reg;
  assign abort_count = abort_count_reg;
  assign busy        = (state_reg != ST_IDLE) || !fifo_empty || retry_reg;

endmodule

// File: tb/tb_ps2_device_emulator.sv
module tb_ps2_device_emulator;

  localparam int HALF  = 5;
  localparam int GAP   = 20;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       host_inhibit = 1'b0;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic       frame_done;
  logic [7:0] abort_count;

  ps2_device_emulator_if tx_if ();

  ps2_device_emulator #(
    .CLK_HZ     (1_000_000),
    .PS2_HZ     (100_000),
    .FIFO_DEPTH (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx           (tx_if.slave),
    .host_inhibit (host_inhibit),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .busy         (busy),
    .frame_done   (frame_done),
    .abort_count  (abort_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Line monitor: decodes frames from the sampled ps2_clk falling edges.
  logic [10:0] frame_q[$];
  int          start_q[$];
  int          fd_q[$];
  int          fall_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    logic        prev_clk;
    logic        prev_data;
    logic [10:0] cur_bits;
    int          nbits;
    int          cur_start;
    prev_clk  = 1'b1;
    prev_data = 1'b1;
    cur_bits  = '0;
    nbits     = 0;
    cur_start = 0;
    forever begin
      @(negedge clk);
      if (reset || host_inhibit) begin
        nbits = 0;
      end else if (prev_clk && !ps2_clk) begin
        fall_q.push_back(cyc);
        cur_bits[nbits] = ps2_data;
        nbits++;
        if (nbits == 11) begin
          frame_q.push_back(cur_bits);
          start_q.push_back(cur_start);
          nbits = 0;
        end
      end else if (ps2_clk && prev_data && !ps2_data && nbits == 0) begin
        cur_start = cyc;
      end
      if (frame_done) fd_q.push_back(cyc);
      prev_clk  = ps2_clk;
      prev_data = ps2_data;
    end
  end

  // Reference frame: bit k is the k-th bit on the wire.
  function automatic logic [10:0] exp_frame(input logic [7:0] d, input logic e);
    logic [10:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ((ones % 2) == 0) ^ e;
    f[10] = 1'b1;
    return f;
  endfunction

  // Called at a negedge; waits (bounded) for room, pushes one byte, returns
  // at the next negedge with the edge number that accepted it.
  task automatic push_byte(input logic [7:0] d, input logic e, output int edge_n);
    int w;
    w = 0;
    while (!tx_if.tx_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!tx_if.tx_ready) begin
      errors++;
      $display("FAIL push_wait: tx_ready=%0b after %0d cycles, required 1", tx_if.tx_ready, w);
    end
    tx_if.tx_data  = d;
    tx_if.tx_err   = e;
    tx_if.tx_valid = 1'b1;
    edge_n = cyc + 1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    $display("push data=%02h err=%0b edge=%0d", d, e, edge_n);
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int w;
    w = 0;
    @(negedge clk);
    while ((busy || !ps2_clk || !ps2_data) && w < max_cyc) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= max_cyc) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%0b after %0d cycles, required 0", tag, busy, w);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ps2_clk, ps2_data, tx_if.tx_ready, busy, frame_done} !== 5'b11100 || abort_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: clk/data/ready/busy/done=%b abort=%0d, required 11100 abort=0",
               {ps2_clk, ps2_data, tx_if.tx_ready, busy, frame_done}, abort_count);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ps2_clk, ps2_data, tx_if.tx_ready, busy, frame_done} !== 5'b11100) begin
      errors++;
      $display("FAIL post_reset_idle: clk/data/ready/busy/done=%b, required 11100",
               {ps2_clk, ps2_data, tx_if.tx_ready, busy, frame_done});
    end
    $display("reset done");
  endtask

  task automatic test_single_byte();
    int fb, db, lb, n;
    fb = frame_q.size(); db = fd_q.size(); lb = fall_q.size();
    push_byte(8'h1C, 1'b0, n);
    wait_idle(400, "single");
    checks++;
    if (frame_q.size() - fb != 1 || fall_q.size() - lb != 11 || fd_q.size() - db != 1) begin
      errors++;
      $display("FAIL single_counts: frames=%0d falls=%0d done=%0d, required 1 11 1",
               frame_q.size() - fb, fall_q.size() - lb, fd_q.size() - db);
    end else begin
      checks++;
      if (frame_q[fb] !== 11'b100_0011_1000) begin
        errors++;
        $display("FAIL single_bits: got %b, required %b", frame_q[fb], 11'b100_0011_1000);
      end
      checks++;
      if (start_q[fb] != n + 2 || fall_q[lb] != n + 2 + HALF) begin
        errors++;
        $display("FAIL single_latency: start=%0d first_fall=%0d, required %0d %0d",
                 start_q[fb], fall_q[lb], n + 2, n + 2 + HALF);
      end
      // frame_done occupies the last cycle; the stop bit ends one cycle later.
      checks++;
      if (fd_q[db] + 1 - start_q[fb] != 22 * HALF) begin
        errors++;
        $display("FAIL single_frame_len: got %0d, required %0d", fd_q[db] + 1 - start_q[fb], 22 * HALF);
      end
    end
    $display("single byte frame=%b", (frame_q.size() > fb) ? frame_q[fb] : 11'h0);
  endtask

  task automatic test_parity_injection();
    int fb, n;
    fb = frame_q.size();
    push_byte(8'h00, 1'b1, n);
    wait_idle(400, "parity");
    checks++;
    if (frame_q.size() - fb != 1) begin
      errors++;
      $display("FAIL parity_count: frames=%0d, required 1", frame_q.size() - fb);
    end else begin
      checks++;
      if (frame_q[fb] !== exp_frame(8'h00, 1'b1) || frame_q[fb][9] !== 1'b0) begin
        errors++;
        $display("FAIL parity_bits: got %b, required %b", frame_q[fb], exp_frame(8'h00, 1'b1));
      end
    end
    $display("parity injection checked");
  endtask

  task automatic test_back_to_back();
    int fb, db, n1, n2;
    fb = frame_q.size(); db = fd_q.size();
    push_byte(8'hF0, 1'b0, n1);
    push_byte(8'h1C, 1'b0, n2);
    wait_idle(600, "b2b");
    checks++;
    if (frame_q.size() - fb != 2 || fd_q.size() - db != 2) begin
      errors++;
      $display("FAIL b2b_counts: frames=%0d done=%0d, required 2 2", frame_q.size() - fb, fd_q.size() - db);
    end else begin
      checks++;
      if (frame_q[fb] !== exp_frame(8'hF0, 1'b0) || frame_q[fb+1] !== exp_frame(8'h1C, 1'b0)) begin
        errors++;
        $display("FAIL b2b_bits: got %b %b, required %b %b", frame_q[fb], frame_q[fb+1],
                 exp_frame(8'hF0, 1'b0), exp_frame(8'h1C, 1'b0));
      end
      checks++;
      if (start_q[fb+1] - (fd_q[db] + 1) != GAP + 2) begin
        errors++;
        $display("FAIL b2b_gap: got %0d, required %0d", start_q[fb+1] - (fd_q[db] + 1), GAP + 2);
      end
    end
    $display("back-to-back checked");
  endtask

  task automatic test_fifo_full();
    logic [7:0] acc[$];
    logic [7:0] d;
    int fb, mcount;
    fb = frame_q.size();
    mcount = 0;
    host_inhibit = 1'b1;  // keeps the device in IDLE so the queue fills
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom);
      checks++;
      if (tx_if.tx_ready !== (mcount < DEPTH)) begin
        errors++;
        $display("FAIL full_ready_%0d: tx_ready=%0b, required %0b", k, tx_if.tx_ready, mcount < DEPTH);
      end
      tx_if.tx_data  = d;
      tx_if.tx_err   = 1'b0;
      tx_if.tx_valid = 1'b1;
      if (mcount < DEPTH) begin
        acc.push_back(d);
        mcount++;
      end
      @(negedge clk);
      $display("full push %0d data=%02h held=%0d", k, d, mcount);
    end
    tx_if.tx_valid = 1'b0;
    checks++;
    if (tx_if.tx_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_hold: ready=%0b busy=%0b, required 0 1", tx_if.tx_ready, busy);
    end
    host_inhibit = 1'b0;
    @(negedge clk);  // LOAD cycle
    checks++;
    if (tx_if.tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_load_ready: tx_ready=%0b, required 0", tx_if.tx_ready);
    end
    @(negedge clk);  // first byte popped
    checks++;
    if (tx_if.tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_after_pop: tx_ready=%0b, required 1", tx_if.tx_ready);
    end
    wait_idle(1200, "full");
    checks++;
    if (frame_q.size() - fb != acc.size()) begin
      errors++;
      $display("FAIL full_count: frames=%0d, required %0d", frame_q.size() - fb, acc.size());
    end else begin
      for (int i = 0; i < acc.size(); i++) begin
        checks++;
        if (frame_q[fb+i] !== exp_frame(acc[i], 1'b0)) begin
          errors++;
          $display("FAIL full_frame_%0d: got %b, required %b", i, frame_q[fb+i], exp_frame(acc[i], 1'b0));
        end
      end
    end
  endtask

  task automatic test_inhibit();
    int fb, db, n, rel;
    fb = frame_q.size(); db = fd_q.size();
    push_byte(8'h5A, 1'b0, n);
    // Bit index 4 low phase spans edges n+47 .. n+51.
    repeat (47) @(negedge clk);
    checks++;
    if (ps2_clk !== 1'b0) begin
      errors++;
      $display("FAIL inhibit_pre: ps2_clk=%0b, required 0", ps2_clk);
    end
    host_inhibit = 1'b1;
    @(negedge clk);
    checks++;
    if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || abort_count !== 8'd1) begin
      errors++;
      $display("FAIL inhibit_release: clk=%0b data=%0b abort=%0d, required 1 1 1", ps2_clk, ps2_data, abort_count);
    end
    repeat (49) @(negedge clk);
    host_inhibit = 1'b0;
    rel = cyc + 1;
    wait_idle(600, "inhibit");
    checks++;
    if (frame_q.size() - fb != 1 || fd_q.size() - db != 1) begin
      errors++;
      $display("FAIL inhibit_counts: frames=%0d done=%0d, required 1 1", frame_q.size() - fb, fd_q.size() - db);
    end else begin
      checks++;
      if (frame_q[fb] !== exp_frame(8'h5A, 1'b0) || start_q[fb] != rel + GAP + 2) begin
        errors++;
        $display("FAIL inhibit_retx: got %b start=%0d, required %b start=%0d",
                 frame_q[fb], start_q[fb], exp_frame(8'h5A, 1'b0), rel + GAP + 2);
      end
    end
    checks++;
    if (abort_count !== 8'd1) begin
      errors++;
      $display("FAIL inhibit_abort_count: got %0d, required 1", abort_count);
    end
    $display("inhibit checked abort_count=%0d", abort_count);
  endtask

  task automatic test_random();
    logic [7:0] exp_d[$];
    logic       exp_e[$];
    logic [7:0] d;
    logic       e;
    int fb, db, n;
    fb = frame_q.size(); db = fd_q.size();
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      d = 8'($urandom);
      e = 1'($urandom_range(0, 1));
      push_byte(d, e, n);
      exp_d.push_back(d);
      exp_e.push_back(e);
    end
    wait_idle(3000, "random");
    checks++;
    if (frame_q.size() - fb != 6 || fd_q.size() - db != 6) begin
      errors++;
      $display("FAIL random_counts: frames=%0d done=%0d, required 6 6", frame_q.size() - fb, fd_q.size() - db);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (frame_q[fb+i] !== exp_frame(exp_d[i], exp_e[i])) begin
          errors++;
          $display("FAIL random_frame_%0d: got %b, required %b", i, frame_q[fb+i], exp_frame(exp_d[i], exp_e[i]));
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, db, lb;
    push_byte(8'h3C, 1'b0, n);
    push_byte(8'hA5, 1'b0, n);
    push_byte(8'h7E, 1'b0, n);
    // Now at edge n; bit index 6 low phase of the first frame is edges n+65..n+69.
    repeat (66) @(negedge clk);
    checks++;
    if (ps2_clk !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre: ps2_clk=%0b, required 0", ps2_clk);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || tx_if.tx_ready !== 1'b1 || busy !== 1'b0 || abort_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_async: clk=%0b data=%0b ready=%0b busy=%0b abort=%0d, required 1 1 1 0 0",
               ps2_clk, ps2_data, tx_if.tx_ready, busy, abort_count);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    db = fd_q.size(); lb = fall_q.size();
    repeat (300) @(negedge clk);
    checks++;
    if (fd_q.size() != db || fall_q.size() != lb || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_quiet: done=%0d falls=%0d busy=%0b, required 0 0 0", fd_q.size() - db, fall_q.size() - lb, busy);
    end
    $display("reset mid-frame checked");
  endtask

  initial begin
    tx_if.tx_data  = 8'h00;
    tx_if.tx_err   = 1'b0;
    tx_if.tx_valid = 1'b0;
    test_reset();
    test_single_byte();
    test_parity_injection();
    test_back_to_back();
    test_fifo_full();
    test_inhibit();
    test_random();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ps2_device_emulator.md
# ps2_device_emulator

Synthesizable PS/2 keyboard emulator that serialises queued scan-code bytes onto the `ps2_clk`/`ps2_data` lines of `game_console`. It replaces the static idle-high PS/2 drive in the console benches, so directed key traffic reaches the keyboard receiver. It adds:
- a byte FIFO,
- parametrised bit rate and inter-frame gap,
- per-byte parity-error injection,
- host-inhibit abort with automatic retransmission.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: system clock frequency.
- `PS2_HZ`, 12_500: PS/2 bit rate. `HALF = CLK_HZ/(2*PS2_HZ)` cycles. Elaboration error if `HALF < 2`.
- `FIFO_DEPTH`, 8: byte queue entries. Power of two, ≥2.
- `GAP_CYCLES`, 4*HALF: idle-high cycles after every frame.

Ports:
- `clk`  in  1  system clock. Everything is sampled on its rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `tx_data`  in  8  scan-code byte to queue.
- `tx_err`  in  1  when set, this byte is sent with inverted parity.
- `tx_valid`  in  1  write request.
- `tx_ready`  out  1  FIFO not full.
- `host_inhibit`  in  1  host pulling the clock low; requests that the device back off.
- `ps2_clk`  out  1  PS/2 clock, idle high.
- `ps2_data`  out  1  PS/2 data, idle high.
- `busy`  out  1  high in every state except IDLE, or while the FIFO is non-empty.
- `frame_done`  out  1  one-cycle pulse at the end of a stop bit.
- `abort_count`  out  8  number of aborted frames. Saturates at 255.

## Operation
- **FIFO**
  - Entries are 9 bits, `{tx_err, tx_data}`.
  - A push happens when `tx_valid && tx_ready`; `tx_ready = !full`.
  - Full with a simultaneous pop: `tx_ready` is still 0 in that cycle and no push occurs.
  - Count width is `$clog2(FIFO_DEPTH+1)`.
- **Frame format:** 11 bits, in order:
  - start bit 0;
  - `data[0]` through `data[7]`, LSB first;
  - odd parity bit, `~^data`, XOR-ed with `err`;
  - stop bit 1.
- **FSM states:** IDLE, LOAD, BIT_HI, BIT_LO, GAP, INHIBIT.
  - **IDLE:** FIFO non-empty and `!host_inhibit` → LOAD.
  - **LOAD:** 1 cycle. Pop the entry into the shift register and set the bit index to 0 → BIT_HI.
  - **BIT_HI:** `ps2_data` = the current bit, `ps2_clk` = 1, for HALF cycles → BIT_LO.
  - **BIT_LO:** `ps2_clk` = 0, data held, for HALF cycles.
    - Bit index < 10: increment the index → BIT_HI.
    - Bit index 10: pulse `frame_done` → GAP.
  - **GAP:** both lines high for `GAP_CYCLES` → IDLE.
  - **INHIBIT:** both lines high until `host_inhibit` falls → GAP, then retransmit the same byte. The byte stays in the shift register; the FIFO is not re-popped.
- **Inhibit handling**
  - `host_inhibit` in BIT_HI or BIT_LO with bit index ≤ 9: abort to INHIBIT and increment `abort_count`.
  - During the stop bit (index 10): ignored; the frame completes.
  - In IDLE or GAP: stalls; no pop occurs.
- **Data changes only while `ps2_clk` is high.** `ps2_data` is stable across every falling edge of `ps2_clk`.
- **Reset:** asynchronous. It empties the FIFO and returns the FSM to IDLE.

## Timing
- Reset values:
  - `ps2_clk` = 1, `ps2_data` = 1;
  - `tx_ready` = 1, `busy` = 0, `frame_done` = 0, `abort_count` = 0.
- `ps2_clk` and `ps2_data` are registered outputs, glitch-free.
- Push at edge N:
  - LOAD in cycle N+1;
  - `ps2_data` falls (start bit) at N+2;
  - first `ps2_clk` falling edge at N+2+HALF.
- A frame lasts 22·HALF cycles from the start of the start bit to the end of the stop bit.
- `frame_done` is asserted in the last BIT_LO cycle of the stop bit.
- Back-to-back bytes: the next start bit begins `GAP_CYCLES`+2 cycles after `frame_done` (GAP, then IDLE, then LOAD).
- Abort: lines go high on the edge after `host_inhibit` is sampled (1-cycle latency).
- A reset asserted mid-frame forces both lines high immediately, with no clock edge required.

## Structure
- Shared package `ps2_pkg` contains:
  - the state enum `ps2_dev_state_t`;
  - constants `PS2_FRAME_BITS` = 11 and `PS2_STOP_IDX` = 10;
  - the function `ps2_parity(data, err)`.
- Sub-module `ps2_byte_fifo`: parametrised-depth synchronous FIFO providing `push`, `pop`, `full`, `empty` and `dout[8:0]`.
- The FSM, half-period counter and shift register live in the top level.

## Test plan
Test parameters: `CLK_HZ`=1_000_000, `PS2_HZ`=100_000 (HALF=5), `GAP_CYCLES`=20, `FIFO_DEPTH`=4.
1. **Single byte:** push 0x1C with `err`=0. Required: `ps2_data` sampled at `ps2_clk` falling edges = 0,0,0,1,1,1,0,0,0,0,1; exactly 11 falling edges; one `frame_done` 110 cycles after the start bit.
2. **Parity injection:** push 0x00 with `err`=1. Required: parity bit 0 (normally 1); all other bits unchanged.
3. **Back-to-back:** push 0xF0 then 0x1C on consecutive cycles. Required: two correct frames, with the second start bit 22 cycles after the first `frame_done`.
4. **FIFO full:** push 5 bytes in 5 consecutive cycles while idle. Required:
   - `tx_ready` = 0 after the 4th push, while the FIFO holds 4 bytes;
   - `tx_ready` = 1 again from the cycle after LOAD of the first byte;
   - every accepted byte is transmitted exactly once, in order.
5. **Inhibit:** push 0x5A and assert `host_inhibit` during bit index 4 for 50 cycles. Required:
   - both lines high one cycle later;
   - `abort_count` = 1;
   - after release, GAP followed by a complete 0x5A frame;
   - `frame_done` pulses only once.
6. **Reset mid-frame:** assert `reset` during bit index 6 with 2 bytes queued. Required: lines high asynchronously, FIFO empty, `busy` = 0, no further frames after reset is released.
